// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among NREQ requesters: accept, execute for one cycle, respond.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-first selection instead of round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 19,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*3-1:0]       req_op,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [2:0]              rsp_flags,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_ovf,
  input  logic                    alu_neg,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   sel_idx;
  logic             sel_found;
  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [2:0]       op_c_p0;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First asserted request at or after rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && sel_found) req_ready = NREQ'(1) << sel_idx;
  end

  assign alu_a    = op_a_p0;
  assign alu_b    = op_b_p0;
  assign alu_ctrl = op_c_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_c_p0    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_valid  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        // Stage 0: latch the winner's operands; they drive the ALU until the next accept.
        IDLE: begin
          if (sel_found) begin
            op_a_p0  <= req_a[sel_idx*WIDTH +: WIDTH];
            op_b_p0  <= req_b[sel_idx*WIDTH +: WIDTH];
            op_c_p0  <= req_op[sel_idx*3 +: 3];
            grant_id <= sel_idx;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        // Stage 1: capture the ALU outputs produced from the stage-0 operands.
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_neg, alu_ovf, alu_zero};
          rsp_valid  <= NREQ'(1) << grant_id;
          state      <= RESP;
        end
        // Stage 2: hold the response until the granted requester takes it.
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`else
            rr_ptr    <= wrap_inc(grant_id);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU and override hooks for flags.
module tb_alu_share_arbiter;
  localparam int WIDTH = 19;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [2:0]            rsp_flags;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [2:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;
  logic                  alu_ovf;
  logic                  alu_neg;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  int                    alu_mode;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: op[2] selects subtract, otherwise add; modes 1/2 force flags for the flag test.
  always_comb begin
    logic [WIDTH-1:0] s;
    s = alu_ctrl[2] ? alu_a - alu_b : alu_a + alu_b;
    alu_result = s;
    alu_zero   = (s == '0);
    alu_neg    = s[WIDTH-1];
    alu_ovf    = 1'b0;
    if (alu_mode == 1) begin
      {alu_neg, alu_ovf, alu_zero} = 3'b011;
    end else if (alu_mode == 2) begin
      alu_result = ~s;
      {alu_neg, alu_ovf, alu_zero} = 3'b100;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int b, input logic [2:0] op);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_op[i*3 +: 3]        = op;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    alu_mode  = 0;
    #2 rst_n = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    rst_n = 1'b1;
    step();

    // Single op from requester 1: 25 + 5 = 30
    set_req(1, 25, 5, 3'b011);
    req_valid = 4'b0010;
    #1 chk("single_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("single_alu_a", 32'(alu_a), 32'd25);
    chk("single_alu_b", 32'(alu_b), 32'd5);
    chk("single_alu_ctrl", 32'(alu_ctrl), 32'h3);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_grant", 32'(grant_id), 32'h1);
    chk("single_no_rsp_exec", 32'(rsp_valid), 32'h0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("single_rsp_result", 32'(rsp_result), 32'd30);
    chk("single_rsp_flags", 32'(rsp_flags), 32'h0);
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    chk("single_done_busy", 32'(busy), 32'h0);
    chk("single_done_rsp", 32'(rsp_valid), 32'h0);
    chk("single_alu_hold", 32'(alu_a), 32'd25);

    // Round-robin from a fresh reset: grants 0,1,2,3,0 every 3 cycles
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 1, 3'b010);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % NREQ;
      #1 chk("rr_req_ready", 32'(req_ready), 32'(1 << g));
      step();
      chk("rr_grant", 32'(grant_id), 32'(g));
      chk("rr_alu_a", 32'(alu_a), 32'(10 + g));
      chk("rr_ready_exec", 32'(req_ready), 32'h0);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << g));
      chk("rr_rsp_result", 32'(rsp_result), 32'(11 + g));
      step();
      chk("rr_idle", 32'(busy), 32'h0);
    end
    req_valid = '0;
    rsp_ready = '0;

    // Back-pressure on requester 2: 26 - 5 = 21
    set_req(2, 26, 5, 3'b100);
    req_valid = 4'b0100;
    #1 chk("bp_req_ready", 32'(req_ready), 32'h4);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("bp_rsp_result", 32'(rsp_result), 32'd21);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      step();
    end
    req_valid = '0;
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    chk("bp_release_busy", 32'(busy), 32'h0);
    chk("bp_release_rsp", 32'(rsp_valid), 32'h0);

    // Flags captured in EXEC only; ALU outputs change during RESP
    set_req(3, 7, 7, 3'b010);
    alu_mode  = 1;
    req_valid = 4'b1000;
    #1 chk("flag_req_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    alu_mode = 2;
    for (int i = 0; i < 3; i++) begin
      #1 chk("flag_rsp_flags", 32'(rsp_flags), 32'h3);
      chk("flag_rsp_result", 32'(rsp_result), 32'd14);
      step();
    end
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;
    alu_mode  = 0;
    chk("flag_done", 32'(busy), 32'h0);

    // Move rr_ptr to 2, then reset during EXEC of requester 2
    set_req(1, 50, 1, 3'b010);
    req_valid = 4'b0010;
    rsp_ready = 4'b1111;
    step();
    req_valid = '0;
    step();
    chk("pre_rst_result", 32'(rsp_result), 32'd51);
    step();
    rsp_ready = '0;
    set_req(2, 100, 1, 3'b010);
    req_valid = 4'b0100;
    #1 chk("midrst_req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("midrst_exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1 chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_alu_a", 32'(alu_a), 32'h0);
    chk("midrst_grant", 32'(grant_id), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_after_rsp", 32'(rsp_valid), 32'h0);
    chk("midrst_after_busy", 32'(busy), 32'h0);
    req_valid = 4'b1111;
    #1 chk("midrst_rr_ptr0", 32'(req_ready), 32'h1);

    // Requesters 1 and 3 held: fixed priority serves 1 only, round-robin alternates
    req_valid = 4'b1010;
    rsp_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      int g;
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 1;
`else
      g = (i % 2 == 0) ? 1 : 3;
`endif
      #1 chk("prio_req_ready", 32'(req_ready), 32'(1 << g));
      step();
      chk("prio_grant", 32'(grant_id), 32'(g));
      step();
      step();
    end
    req_valid = '0;
    rsp_ready = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential arbiter that shares the single combinational 19-bit ALU among up to NREQ requesters (datapath stages, address generation, test logic). It accepts one operation at a time over a valid/ready handshake and drives the ALU's A, B and ALUControl inputs from registered operands. It captures Result and the Zero/OverFlow/Negative flags, then returns them to the granted requester over a valid/ready response channel. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
- WIDTH, 19, operand/result width; must match the ALU.
- NREQ, 4, number of requesters, 2..8.
- IDW, $clog2(NREQ), grant index width (derived).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_op  in  NREQ*3  ALUControl code, slice [i*3 +: 3].
- rsp_valid  out  NREQ  response valid to the granted requester; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  WIDTH  captured ALU Result; shared by all requesters.
- rsp_flags  out  3  captured flags, packed {Negative, OverFlow, Zero}.
- alu_a, alu_b  out  WIDTH  to the ALU A and B inputs.
- alu_ctrl  out  3  to the ALU ALUControl input.
- alu_result  in  WIDTH  from ALU Result.
- alu_zero, alu_ovf, alu_neg  in  1  from ALU Zero, OverFlow, Negative.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  IDW  index of the current or last granted requester.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC: on a handshake (req_valid[g] & req_ready[g]).
  - EXEC → RESP: unconditional.
  - RESP → IDLE: when rsp_ready[g] is high.
- In IDLE, g is selected combinationally among the asserted req_valid bits. The search starts at rr_ptr and wraps upward: rr_ptr, rr_ptr+1, …, NREQ-1, 0, ….
- req_ready[g] is asserted only in IDLE, and only for the selected g.
- Handshake edge: opA, opB, opC and grant_id are loaded from slice g.
- alu_a/alu_b/alu_ctrl are always driven from opA/opB/opC. They hold their values in IDLE and RESP; there is no glitching between operations.
- EXEC edge: rsp_result is loaded from alu_result; rsp_flags from {alu_neg, alu_ovf, alu_zero}.
- RESP: rsp_valid[grant_id] is high. rsp_result and rsp_flags are stable until the accepting edge.
- Response accept (RESP with rsp_ready[grant_id]): rr_ptr is set to grant_id+1, wrapping NREQ-1 → 0.
- Op codes pass through unmodified. The arbiter does not interpret ALUControl.
- Requesters must hold req_* stable while req_valid is high and not yet accepted. A requester may drop req_valid before acceptance with no effect.
- rsp_ready from non-granted requesters is ignored.
- Reset mid-operation: the FSM returns to IDLE immediately. Any in-flight operation is discarded and no response is issued.
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0.
  - opA, opB, opC 0, so alu_* outputs are 0.
  - rsp_result 0, rsp_flags 0, busy 0.
  - req_ready and rsp_valid 0.

## Timing
- Accept at edge N → ALU driven during cycle N..N+1 → result captured at edge N+1 → rsp_valid high after edge N+1.
- Minimum turnaround: a response accepted at edge M allows a new accept at edge M+1. Peak throughput is one operation per 3 cycles.
- req_ready is combinational from state, rr_ptr and req_valid. No combinational path exists from rsp_ready to any output other than through state.
- Back-pressure: RESP holds indefinitely while rsp_ready[grant_id] is low. req_ready stays 0 throughout.
- Simultaneous requests: exactly one is granted per accept. Losers keep req_valid asserted and are served in rotation; starvation is impossible under round-robin.
- rsp_flags reflect only the EXEC-cycle ALU outputs. Later ALU input changes do not affect them.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: selection is fixed priority, lowest index first. rr_ptr is held at 0 and never updated.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset and single op:
  - Stimulus: deassert rst_n; then req 1 with A=25, B=5, op=3'b011.
  - Required: all outputs 0 during reset; req_ready=4'b0010 in IDLE; alu_a=25, alu_b=5, alu_ctrl=3'b011 from the next cycle; rsp_valid=4'b0010 after 2 edges; rsp_result and rsp_flags equal the ALU outputs in EXEC.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, each with distinct A (10, 11, 12, 13), op 3'b010, rsp_ready all 1.
  - Required: grant order 0, 1, 2, 3, 0; each accept spaced 3 cycles apart.
- Back-pressure:
  - Stimulus: req 2 with A=26, B=5, op=3'b100; rsp_ready low for 5 cycles.
  - Required: rsp_valid[2] held, rsp_result stable, req_ready=0 and busy=1 throughout; IDLE on the cycle after rsp_ready rises.
- Flags:
  - Stimulus: the bench ALU model returns zero=1, ovf=1, neg=0 during EXEC, then changes its outputs in RESP.
  - Required: rsp_flags=3'b011 for the whole RESP.
- Reset mid-op:
  - Stimulus: assert rst_n low during EXEC.
  - Required: immediate IDLE; rsp_valid never asserted for that op; rr_ptr 0.
- Fixed-priority build:
  - Stimulus: with ALU_ARB_FIXED_PRIO_EN defined, req_valid=4'b1010 held continuously.
  - Required: requester 1 granted every time; requester 3 never granted.
